// File: rtl/sm_hazard_scoreboard_if.sv
// sm_hazard_scoreboard_if: D-stage issue, writeback and hazard bundle.
// master = pipeline side, slave = scoreboard side.
interface sm_hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3
);
  logic              issue_valid;
  logic              issue_we;
  logic [REG_AW-1:0] issue_rd;
  logic [CNT_W-1:0]  issue_lat;
  logic              use_rs;
  logic              use_rt;
  logic [REG_AW-1:0] rs_D;
  logic [REG_AW-1:0] rt_D;
  logic              done_valid;
  logic [REG_AW-1:0] done_rd;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;
  logic              hz_stall_n_F;
  logic              hz_stall_n_D;
  logic              hz_flush_n_E;
  logic [CNT_W:0]    inflight;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat,
    output use_rs, use_rt, rs_D, rt_D,
    output done_valid, done_rd, wb_valid, wb_rd,
    input  hz_stall_n_F, hz_stall_n_D, hz_flush_n_E,
    input  inflight
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat,
    input  use_rs, use_rt, rs_D, rt_D,
    input  done_valid, done_rd, wb_valid, wb_rd,
    output hz_stall_n_F, hz_stall_n_D, hz_flush_n_E,
    output inflight
  );
endinterface

// File: rtl/sm_hazard_scoreboard.sv
// sm_hazard_scoreboard: per-register busy/countdown hazard unit.
// Optional WAW ordering stall enabled by defining SM_HZ_SB_WAW_EN.
module sm_hazard_scoreboard #(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 3,
  parameter int MAX_INFLIGHT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  sm_hazard_scoreboard_if.slave hz
);
  localparam int NREG = 1 << REG_AW;
  localparam logic [CNT_W-1:0] LAT_INF = '1;
  localparam logic [CNT_W:0] MAX_Q = (CNT_W+1)'(MAX_INFLIGHT);

  logic [NREG-1:0]            busy_q, busy_d;
  logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]             inflight_q, inflight_d;

  logic raw_rs, raw_rt, raw;
  logic waw, full, stall, accept;
  logic wb_hit, iss_hit;

  // Hazard detection from current state and D-stage inputs.
  always_comb begin
    raw_rs = hz.use_rs && (hz.rs_D != '0) &&
             busy_q[hz.rs_D] && (cnt_q[hz.rs_D] != '0);
    raw_rt = hz.use_rt && (hz.rt_D != '0) &&
             busy_q[hz.rt_D] && (cnt_q[hz.rt_D] != '0);
    raw    = raw_rs || raw_rt;
    wb_hit = hz.wb_valid && (hz.wb_rd != '0) &&
             busy_q[hz.wb_rd] && (inflight_q != '0);
    // A retiring write in the same cycle frees a slot.
    full   = hz.issue_we && (inflight_q == MAX_Q) && !wb_hit;
`ifdef SM_HZ_SB_WAW_EN
    // LAT_INF is all ones so it compares as the longest latency.
    waw    = hz.issue_we && (hz.issue_rd != '0) &&
             busy_q[hz.issue_rd] &&
             (cnt_q[hz.issue_rd] > hz.issue_lat);
`else
    waw    = 1'b0;
`endif
    stall   = hz.issue_valid && (raw || full || waw);
    accept  = hz.issue_valid && !stall;
    iss_hit = accept && hz.issue_we && (hz.issue_rd != '0);
  end

  assign hz.hz_stall_n_F = !stall;
  assign hz.hz_stall_n_D = !stall;
  assign hz.hz_flush_n_E = !stall;
  assign hz.inflight     = inflight_q;

  // Per-entry update: issue > wb > done > countdown.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int r = 1; r < NREG; r++) begin
      if (iss_hit && (hz.issue_rd == REG_AW'(r))) begin
        busy_d[r] = 1'b1;
        cnt_d[r]  = hz.issue_lat;
      end else if (wb_hit && (hz.wb_rd == REG_AW'(r))) begin
        busy_d[r] = 1'b0;
        cnt_d[r]  = '0;
      end else if (hz.done_valid && (hz.done_rd == REG_AW'(r)) &&
                   busy_q[r] && (cnt_q[r] == LAT_INF)) begin
        cnt_d[r]  = '0;
      end else if ((cnt_q[r] != '0) && (cnt_q[r] != LAT_INF)) begin
        cnt_d[r]  = cnt_q[r] - CNT_W'(1);
      end
    end
    busy_d[0] = 1'b0;
    cnt_d[0]  = '0;
    unique case ({iss_hit, wb_hit})
      2'b10:   inflight_d = inflight_q + (CNT_W+1)'(1);
      2'b01:   inflight_d = inflight_q - (CNT_W+1)'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end
endmodule

// File: tb/tb_sm_hazard_scoreboard.sv
// tb_sm_hazard_scoreboard: queued-expectation bench with a
// cycle-timestamp reference model of the hazard rules.
module tb_sm_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int CW   = 3;
  localparam int MAXI = 4;
  localparam int LINF = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_hazard_scoreboard_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

  sm_hazard_scoreboard #(
    .REG_AW(AW), .CNT_W(CW), .MAX_INFLIGHT(MAXI)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (hz)
  );

  typedef struct {
    bit sn;
    int infl;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: result of reg r forwardable from cycle m_ready[r].
  bit m_busy[32];
  bit m_inf[32];
  int m_ready[32];
  int m_infl;
  int now;

  function automatic int rem(input int r);
    if (!m_busy[r]) return 0;
    if (m_inf[r]) return LINF;
    return (m_ready[r] > now) ? m_ready[r] - now : 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 0;
      m_inf[r] = 0;
      m_ready[r] = 0;
    end
    m_infl = 0;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  // Monitor: pop one expectation per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("stall_n_F", 32'(hz.hz_stall_n_F), 32'(e.sn));
      cmp("stall_n_D", 32'(hz.hz_stall_n_D), 32'(e.sn));
      cmp("flush_n_E", 32'(hz.hz_flush_n_E), 32'(e.sn));
      cmp("inflight", 32'(hz.inflight), e.infl);
    end
  end

  task automatic drive_idle();
    hz.issue_valid = 0; hz.issue_we = 0;
    hz.issue_rd = '0; hz.issue_lat = '0;
    hz.use_rs = 0; hz.use_rt = 0;
    hz.rs_D = '0; hz.rt_D = '0;
    hz.done_valid = 0; hz.done_rd = '0;
    hz.wb_valid = 0; hz.wb_rd = '0;
  endtask

  task automatic step(
    input bit iv, input bit we, input int rd, input int lat,
    input bit urs, input int rs, input bit urt, input int rt,
    input bit dv, input int drd, input bit wv, input int wrd,
    output bit obs
  );
    bit raw, full, waw, stl, acc, wbf, ins;
    exp_t e;
    @(posedge clk);
    #1;
    hz.issue_valid = iv; hz.issue_we = we;
    hz.issue_rd = AW'(rd); hz.issue_lat = CW'(lat);
    hz.use_rs = urs; hz.use_rt = urt;
    hz.rs_D = AW'(rs); hz.rt_D = AW'(rt);
    hz.done_valid = dv; hz.done_rd = AW'(drd);
    hz.wb_valid = wv; hz.wb_rd = AW'(wrd);
    raw = (urs && rs != 0 && rem(rs) != 0) ||
          (urt && rt != 0 && rem(rt) != 0);
    wbf = wv && wrd != 0 && m_busy[wrd] && m_infl > 0;
    full = we && m_infl == MAXI && !wbf;
`ifdef SM_HZ_SB_WAW_EN
    waw = we && rd != 0 && m_busy[rd] && rem(rd) > lat;
`else
    waw = 0;
`endif
    stl = iv && (raw || full || waw);
    acc = iv && !stl;
    ins = acc && we && rd != 0;
    e.sn = !stl;
    e.infl = m_infl;
    q.push_back(e);
    #1 obs = hz.hz_stall_n_D;
    if (dv && drd != 0 && m_busy[drd] && m_inf[drd]) begin
      m_inf[drd] = 0;
      m_ready[drd] = now + 1;
    end
    if (wbf) m_busy[wrd] = 0;
    if (ins) begin
      m_busy[rd] = 1;
      m_inf[rd] = (lat == LINF);
      m_ready[rd] = now + 1 + lat;
    end
    m_infl = m_infl + int'(ins) - int'(wbf);
    now++;
  endtask

  task automatic wb(input int r);
    bit o;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r, o);
  endtask

  task automatic issue(input int r, input int lat, output bit o);
    step(1, 1, r, lat, 0, 0, 0, 0, 0, 0, 0, 0, o);
  endtask

  initial begin
    bit o;
    int n;
    drive_idle();
    model_reset();
    now = 0;
    #2;
    cmp("rst_stall_n_F", 32'(hz.hz_stall_n_F), 1);
    cmp("rst_stall_n_D", 32'(hz.hz_stall_n_D), 1);
    cmp("rst_flush_n_E", 32'(hz.hz_flush_n_E), 1);
    cmp("rst_inflight", 32'(hz.inflight), 0);
    #10 rst_n = 1'b1;

    // ALU result forwarded immediately.
    issue(3, 0, o);
    step(1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, o);
    cmp("alu_no_stall", 32'(o), 1);
    wb(3);

    // Load-use: exactly one bubble.
    issue(5, 1, o);
    n = 0;
    o = 0;
    for (int i = 0; i < 5 && !o; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, o);
      if (!o) n++;
    end
    cmp("load_stall_cycles", n, 1);
    wb(5);

    // Unknown latency: stall until done, accept next cycle.
    issue(7, LINF, o);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8, 0, 1, 7, 0, 0, i == 9, 7, 0, 0, o);
      if (!o) n++;
    end
    cmp("mul_stall_cycles", n, 10);
    step(1, 1, 8, 0, 1, 7, 0, 0, 0, 0, 0, 0, o);
    cmp("mul_accept_after_done", 32'(o), 1);
    wb(7);
    wb(8);

    // Structural limit and same-cycle release.
    for (int r = 1; r <= 4; r++) issue(r, 0, o);
    issue(5, 0, o);
    cmp("full_stall", 32'(o), 0);
    step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, o);
    cmp("full_wb_accept", 32'(o), 1);
    for (int r = 2; r <= 5; r++) wb(r);

    // Issue and retire of the same register in one cycle.
    issue(9, 2, o);
    step(1, 1, 9, 3, 0, 0, 0, 0, 0, 0, 1, 9, o);
    cmp("iss_wb_same_rd", 32'(o), 1);
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, o);
    cmp("r0_no_stall", 32'(o), 1);
    step(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, o);
    cmp("r9_new_cnt_stall", 32'(o), 0);
    wb(9);

    // Younger short write behind a pending unknown-latency write.
    issue(4, LINF, o);
    n = 0;
    o = 0;
    for (int i = 0; i < 6 && !o; i++) begin
      step(1, 1, 4, 0, 0, 0, 0, 0, i == 2, 4, 0, 0, o);
      if (!o) n++;
    end
`ifdef SM_HZ_SB_WAW_EN
    cmp("waw_stall_cycles", n, 3);
`else
    cmp("waw_stall_cycles", n, 0);
`endif
    wb(4);

    // Reset in the middle of activity.
    issue(10, 2, o);
    issue(11, LINF, o);
    @(negedge clk);
    #1;
    drive_idle();
    rst_n = 1'b0;
    #1;
    cmp("midrst_inflight", 32'(hz.inflight), 0);
    cmp("midrst_stall_n", 32'(hz.hz_stall_n_D), 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      bit iv, we, urs, urt, dv, wv;
      int rd, lat, rs, rt, drd, wrd;
      int cand[$];
      iv = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 1) != 0;
      rd = $urandom_range(0, 7);
      if (m_busy[rd]) rd = 0;
      case ($urandom_range(0, 3))
        0: lat = 0;
        1: lat = 1;
        2: lat = 2;
        default: lat = LINF;
      endcase
      urs = $urandom_range(0, 1) != 0;
      urt = $urandom_range(0, 1) != 0;
      rs = $urandom_range(0, 7);
      rt = $urandom_range(0, 7);
      cand.delete();
      for (int r = 1; r < 8; r++)
        if (m_busy[r] && m_inf[r]) cand.push_back(r);
      dv = 0;
      drd = $urandom_range(0, 7);
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        dv = 1;
        drd = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        dv = 1;
      end
      cand.delete();
      for (int r = 1; r < 8; r++)
        if (m_busy[r] && !m_inf[r] && rem(r) == 0) cand.push_back(r);
      wv = 0;
      wrd = $urandom_range(0, 7);
      if (cand.size() > 0 && $urandom_range(0, 1) == 0) begin
        wv = 1;
        wrd = cand[$urandom_range(0, cand.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        wv = 1;
      end
      step(iv, we, rd, lat, urs, rs, urt, rt, dv, drd, wv, wrd, o);
    end

    @(posedge clk);
    #1;
    drive_idle();
    n = 0;
    while (q.size() > 0 && n < 5) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending %0d required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
